// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: FSM encodings and default
// timing constants derived from the 100 MHz system clock.
package pong_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // 250 ms visible/audible pulse, 25 ms separation between pulses.
  localparam int unsigned HOLD_DEFAULT = CLK_HZ / 4;
  localparam int unsigned GAP_DEFAULT  = CLK_HZ / 40;

  // Wide enough for HOLD_DEFAULT - 1.
  localparam int unsigned STRETCH_CNT_W_DEFAULT = 25;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StGap  = 2'd2
  } stretch_state_e;

endpackage

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event strobes into fixed-length output
// levels (LEDs, buzzer enable) separated by a forced low gap. One further
// event may be queued; anything beyond that is discarded and flagged on drop.
//
// Build option PULSE_STRETCHER_RETRIGGER_EN: an event arriving while the
// output is high restarts the hold time instead of queueing.
module pulse_stretcher
  import pong_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_DEFAULT,           // >= 1
  parameter int unsigned GAP_CYCLES  = GAP_DEFAULT,            // 0 disables the gap
  parameter int unsigned CNT_W       = STRETCH_CNT_W_DEFAULT   // 2**CNT_W > max(hold, gap)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
  // Only used when a gap exists; guarded so GAP_CYCLES == 0 cannot underflow.
  localparam logic [CNT_W-1:0] GapLoad  = (GAP_CYCLES != 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  stretch_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  // Event as seen by a transition on the same edge: queued ahead of it.
  logic             ev_queued;
  logic             ev_drop;

  assign ev_queued = pend_q | in;
  assign ev_drop   = pend_q & in;

  // State register: FSM, counter, pending flag and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: hold/gap timing, event queueing and discard detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end

      StHold: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (in) begin
          // Retrigger: extend the current pulse, nothing is queued.
          cnt_d = HoldLoad;
        end else if (cnt_q == '0) begin
          if (GAP_CYCLES != 0) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else if (pend_q) begin
            cnt_d  = HoldLoad;
            pend_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
`else
        pend_d = ev_queued;
        drop_d = ev_drop;
        if (cnt_q == '0) begin
          if (GAP_CYCLES != 0) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else if (ev_queued) begin
            // No gap: back-to-back holds merge into one continuous level.
            cnt_d  = HoldLoad;
            pend_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
`endif
      end

      StGap: begin
        pend_d = ev_queued;
        drop_d = ev_drop;
        if (cnt_q == '0) begin
          if (ev_queued) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so outputs register alongside it.
  always_comb begin
    out_d  = (state_d == StHold);
    busy_d = (state_d != StIdle) | pend_d;
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: two instances (HOLD=4 with GAP=2
// and with GAP=0) share one input and are compared every cycle against a
// model that tracks pulse start times on an absolute timeline.
module tb_pulse_stretcher;

  localparam int unsigned Hold = 4;
  localparam int unsigned GapA = 2;
  localparam int unsigned GapB = 0;

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic out_a, busy_a, drop_a;
  logic out_b, busy_b, drop_b;

  int n_cmp = 0;
  int n_mis = 0;
  longint t = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(Hold), .GAP_CYCLES(GapA), .CNT_W(4)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .out  (out_a),
    .busy (busy_a),
    .drop (drop_a)
  );

  pulse_stretcher #(.HOLD_CYCLES(Hold), .GAP_CYCLES(GapB), .CNT_W(4)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .out  (out_b),
    .busy (busy_b),
    .drop (drop_b)
  );

  // Model: s = edge at which the current/last hold started. Output high on
  // cycles after edges s .. s+Hold-1, gap follows, then idle.
  typedef struct {
    longint s;
    bit     pend;
    bit     drop;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(longint now);
    mdl_t m;
    m.s    = now - 1000;
    m.pend = 1'b0;
    m.drop = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m_in, int unsigned g, bit ev, longint now);
    mdl_t   m;
    longint hold_end;
    longint free_at;
    m        = m_in;
    m.drop   = 1'b0;
    hold_end = m.s + longint'(Hold);
    free_at  = hold_end + longint'(g);
    if (now > m.s && now <= hold_end) begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      if (ev) begin
        m.s = now;
        return m;
      end
`endif
      if (ev) begin
        if (m.pend) m.drop = 1'b1;
        else m.pend = 1'b1;
      end
      if (now == hold_end && g == 0 && m.pend) begin
        m.s    = now;
        m.pend = 1'b0;
      end
    end else if (now > hold_end && now <= free_at) begin
      if (ev) begin
        if (m.pend) m.drop = 1'b1;
        else m.pend = 1'b1;
      end
      if (now == free_at && m.pend) begin
        m.s    = now;
        m.pend = 1'b0;
      end
    end else if (ev) begin
      m.s = now;
    end
    return m;
  endfunction

  function automatic bit mdl_out(mdl_t m, longint now);
    return (now >= m.s) && (now < m.s + longint'(Hold));
  endfunction

  function automatic bit mdl_busy(mdl_t m, int unsigned g, longint now);
    return (now < m.s + longint'(Hold) + longint'(g)) || m.pend;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // One clock: drive in, step the models at the edge, compare at the falling edge.
  task automatic tick(input bit ev);
    in = ev;
    @(posedge clk);
    t++;
    ma = mdl_step(ma, GapA, ev, t);
    mb = mdl_step(mb, GapB, ev, t);
    @(negedge clk);
    check("out_a",  32'(out_a),  32'(mdl_out(ma, t)));
    check("busy_a", 32'(busy_a), 32'(mdl_busy(ma, GapA, t)));
    check("drop_a", 32'(drop_a), 32'(ma.drop));
    check("out_b",  32'(out_b),  32'(mdl_out(mb, t)));
    check("busy_b", 32'(busy_b), 32'(mdl_busy(mb, GapB, t)));
    check("drop_b", 32'(drop_b), 32'(mb.drop));
  endtask

  // Asynchronous reset pulse inside a low clock phase; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    ma = mdl_reset(t);
    mb = mdl_reset(t);
    check({tag, "_out"},  32'({out_a, out_b}),   32'd0);
    check({tag, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
    check({tag, "_drop"}, 32'({drop_a, drop_b}), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  logic [31:0] h_out_a, h_busy_a, h_drop_a, h_out_b, h_drop_b;

  // Run scenario cycles 1..24 with events at the set bits of pat; bit c of a
  // history word holds the output seen during cycle c.
  task automatic run_pattern(input logic [31:0] pat);
    h_out_a  = '0;
    h_busy_a = '0;
    h_drop_a = '0;
    h_out_b  = '0;
    h_drop_b = '0;
    for (int c = 1; c <= 24; c++) begin
      tick(pat[c]);
      h_out_a[c+1]  = out_a;
      h_busy_a[c+1] = busy_a;
      h_drop_a[c+1] = drop_a;
      h_out_b[c+1]  = out_b;
      h_drop_b[c+1] = drop_b;
    end
  endtask

  logic [31:0] pat;
  logic [31:0] h_after;

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    ma  = mdl_reset(0);
    mb  = mdl_reset(0);
    repeat (2) @(negedge clk);
    check("reset_out",  32'({out_a, out_b}),   32'd0);
    check("reset_busy", 32'({busy_a, busy_b}), 32'd0);
    check("reset_drop", 32'({drop_a, drop_b}), 32'd0);
    rst = 1'b0;

    // Single event at cycle 10.
    pulse_reset("s1_rst");
    pat = 32'h0000_0400;
    run_pattern(pat);
    check("s1_out_a",  h_out_a,  32'h0000_7800);
    check("s1_busy_a", h_busy_a, 32'h0001_f800);
    check("s1_drop_a", h_drop_a, 32'h0000_0000);

    // Events at 10 and 12.
    pulse_reset("s2_rst");
    pat = 32'h0000_1400;
    run_pattern(pat);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s5_out_a",  h_out_a,  32'h0001_f800);
    check("s5_busy_a", h_busy_a, 32'h0007_f800);
    check("s5_out_b",  h_out_b,  32'h0001_f800);
`else
    check("s2_out_a",  h_out_a,  32'h001e_7800);
    check("s2_busy_a", h_busy_a, 32'h007f_f800);
    check("s6_out_b",  h_out_b,  32'h0007_f800);
`endif
    check("s2_drop_a", h_drop_a, 32'h0000_0000);

    // Events at 10, 12 and 13.
    pulse_reset("s3_rst");
    pat = 32'h0000_3400;
    run_pattern(pat);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s3_drop_a", h_drop_a, 32'h0000_0000);
    check("s3_drop_b", h_drop_b, 32'h0000_0000);
`else
    check("s3_out_a",  h_out_a,  32'h001e_7800);
    check("s3_drop_a", h_drop_a, 32'h0000_4000);
    check("s3_drop_b", h_drop_b, 32'h0000_4000);
`endif

    // Reset during HOLD with an event pending: nothing may follow.
    pulse_reset("s4_rst");
    for (int c = 1; c <= 11; c++) tick(c >= 10);
    pulse_reset("s4_mid");
    h_after = '0;
    for (int c = 12; c <= 24; c++) begin
      tick(1'b0);
      h_after[c-11] = out_a | out_b | busy_a | busy_b;
    end
    check("s4_after", h_after, 32'd0);

    // Event on the first edge after release is accepted.
    pulse_reset("s4b_rst");
    tick(1'b1);
    check("s4b_first", 32'({out_a, out_b}), 32'b11);
    repeat (8) tick(1'b0);

    // Random traffic with varying density and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      int unsigned dens;
      dens = (i / 500) % 4;
      if ($urandom_range(0, 599) == 0) pulse_reset("rnd_rst");
      unique case (dens)
        0: tick($urandom_range(0, 7) == 0);
        1: tick($urandom_range(0, 1) == 0);
        2: tick($urandom_range(0, 3) != 0);
        default: tick($urandom_range(0, 19) == 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
